pmc_transmitter: RTL and testbench
==================================

# pmc_transmitter

Parallel-to-serial transmitter that loads 32 column words of 16 bits into the pixel matrix over the serial shift interface. It is the write-direction counterpart of the PMC receiver: the same `sh`/`pclk` framing, MSB-first bit order and 16-bit word length. It takes a parallel snapshot of `dout` and drives one bit per column on `pm_din` for each `pclk` strobe. It sits in the PMC between the register-mapped data path and the matrix data inputs.

## Interface

Parameters: none (32 columns, 16-bit words, fixed by the matrix).

- `clk` input 1: system clock; all logic on its rising edge
- `rst_n` input 1: reset, asynchronous and active-low
- `sh` input 1: shift-enable window from the PMC controller, level-sensitive
- `pclk` input 1: shift strobe, single-`clk`-cycle pulse, synchronous to `clk`
- `dout` input [31:0][15:0]: parallel words to transmit, one per column
- `pm_din` output 32: serial data to the matrix, bit `i` belongs to column `i`
- `busy` output 1: high whenever state ≠ IDLE
- `word_done` output 1: one-cycle pulse after the 16th bit of a word has been shifted

## Operation

- Internal state:
  - FSM with states IDLE, WAITING, ACTIVE.
  - 4-bit `bits_counter`.
  - Shadow register `shadow[31:0][15:0]`.
  - All outputs registered.
- Reset (asynchronous, `rst_n`=0):
  - state=IDLE, `bits_counter`=0, `shadow`=0.
  - `pm_din`=0, `word_done`=0, `busy`=0.
- IDLE:
  - `pm_din` holds 0; `pclk` is ignored.
  - `sh`=1: go to WAITING, set `shadow`<=`dout`, set `pm_din[i]`<=`dout[i][15]`.
- WAITING: the MSB of the current word is on `pm_din`.
  - `pclk`=1 has priority over `sh`: go to ACTIVE, `bits_counter`<=1, `pm_din[i]`<=`shadow[i][14]`.
  - Else, if `sh`=0: go to IDLE, `pm_din`<=0, `bits_counter`<=0. The snapshot is discarded.
- ACTIVE: `sh` is ignored, so a started word always completes.
  - `pclk`=1 and `bits_counter`<15: `bits_counter`<=`bits_counter`+1, `pm_din[i]`<=`shadow[i][15-(bits_counter+1)]`.
  - `pclk`=1 and `bits_counter`=15:
    - go to WAITING, `bits_counter`<=0, `word_done`<=1;
    - reload `shadow`<=`dout`;
    - set `pm_din[i]`<=`dout[i][15]` (next word's MSB is pre-presented).
  - `pclk`=0: hold.
- Bit order: MSB first. The k-th `pclk` of a word (k=1..16) is the cycle in which `pm_din[i]`=`word[i][16-k]`. A receiver sampling `pm_din` in `pclk`-high cycles therefore reconstructs `dout` exactly.
- `dout` is sampled only on the IDLE→WAITING and ACTIVE→WAITING transitions. Changes at any other time have no effect on the word in flight.
- `word_done`:
  - `word_done` is 0 in every cycle except the one following the 16th `pclk`.
  - It is not asserted on an aborted WAITING→IDLE exit.

## Timing

- `sh` rising, sampled at edge N: state and `pm_din` (MSB) are valid from edge N.
  - The first `pclk` is honoured at edge N+1 at the earliest.
  - A `pclk` coincident with the `sh` sample in IDLE is dropped.
- After each honoured `pclk`, the next bit is on `pm_din` from the same edge. Minimum `pclk` spacing is 1 cycle; back-to-back strobes are allowed.
- Word latency: 16 `pclk` strobes. `word_done` is high for the one cycle after the edge that samples the 16th strobe.
- Words are back-to-back with no gap: a 17th `pclk` immediately following is bit 15 of the reloaded word.
- `busy` is registered with the state: high from the edge after `sh` is sampled, low from the edge that enters IDLE.
- Reset mid-word: all outputs go to reset values immediately (asynchronously); the partial word is lost.

## Test plan

- Single word:
  - Stimulus: `dout[0]`=0xA5C3, `dout[31]`=0x8001, others 0; `sh`=1, then 16 `pclk` pulses spaced 3 cycles.
  - Required response: `pm_din[0]` in `pclk` cycles = 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1; `pm_din[31]` = 1, then 14 zeros, then 1; `word_done` pulses once.
- All columns, back-to-back `pclk`:
  - Stimulus: random `dout`; 16 consecutive `pclk` cycles.
  - Required response: a reference receiver model reconstructs all 32 words; `busy` stays 1.
- Two words:
  - Stimulus: `dout` changed to 0x1234 (all columns) mid-word 1; 32 `pclk` pulses.
  - Required response: word 1 equals the original snapshot; word 2 = 0x1234 in every column; two `word_done` pulses.
- Abort:
  - Stimulus: `sh` dropped in WAITING with no `pclk`.
  - Required response: IDLE next cycle, `pm_din`=0, `busy`=0, no `word_done`.
  - Stimulus: `sh` dropped after 5 `pclk` pulses.
  - Required response: the word still completes on the remaining 11 strobes, and the FSM then goes WAITING→IDLE.
- Edge stimuli:
  - Stimulus: `pclk` in the same cycle as the first `sh` sample.
  - Required response: the strobe is ignored and `bits_counter` stays 0.
  - Stimulus: `rst_n` asserted after 8 bits.
  - Required response: all outputs 0 immediately; a fresh word then transmits correctly.

Source files
------------

// File: rtl/pmc_transmitter.sv
// Parallel-to-serial loader for the pixel matrix: snapshots 32 column words and shifts them out
// MSB first, one bit per column on each pclk strobe inside the sh window.
module pmc_transmitter (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sh,
    input  logic             pclk,
    input  logic [31:0][15:0] dout,
    output logic [31:0]      pm_din,
    output logic             busy,
    output logic             word_done
);

    typedef enum logic [1:0] {StIdle, StWaiting, StActive} state_t;

    state_t            state;
    logic [3:0]        bits_counter;
    logic [31:0][15:0] shadow;

    logic [3:0]  next_idx;
    logic [31:0] dout_msb;
    logic [31:0] shadow_bit;

    // Index of the bit presented after the current strobe; 14 while WAITING (counter is 0).
    always_comb begin
        next_idx   = 4'd14 - bits_counter;
        dout_msb   = '0;
        shadow_bit = '0;
        for (int i = 0; i < 32; i++) begin
            dout_msb[i]   = dout[i][15];
            shadow_bit[i] = shadow[i][next_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= StIdle;
            bits_counter <= '0;
            shadow       <= '0;
            pm_din       <= '0;
            busy         <= 1'b0;
            word_done    <= 1'b0;
        end else begin
            word_done <= 1'b0;
            case (state)
                StIdle: begin
                    if (sh) begin
                        state  <= StWaiting;
                        busy   <= 1'b1;
                        shadow <= dout;
                        pm_din <= dout_msb;
                    end
                end
                StWaiting: begin
                    if (pclk) begin
                        state        <= StActive;
                        bits_counter <= 4'd1;
                        pm_din       <= shadow_bit;
                    end else if (!sh) begin
                        state        <= StIdle;
                        busy         <= 1'b0;
                        bits_counter <= '0;
                        pm_din       <= '0;
                    end
                end
                StActive: begin
                    // sh is ignored here so a started word always completes.
                    if (pclk) begin
                        if (bits_counter == 4'd15) begin
                            state        <= StWaiting;
                            bits_counter <= '0;
                            word_done    <= 1'b1;
                            shadow       <= dout;
                            pm_din       <= dout_msb;
                        end else begin
                            bits_counter <= bits_counter + 4'd1;
                            pm_din       <= shadow_bit;
                        end
                    end
                end
                default: begin
                    state        <= StIdle;
                    busy         <= 1'b0;
                    bits_counter <= '0;
                    pm_din       <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pmc_transmitter.sv
// Self-checking bench for pmc_transmitter: a reference receiver rebuilds words from pm_din
// in pclk-high cycles and compares them with the snapshots the bench expects.
module tb_pmc_transmitter;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             sh = 1'b0;
    logic             pclk = 1'b0;
    logic [31:0][15:0] dout = '0;
    logic [31:0]      pm_din;
    logic             busy;
    logic             word_done;

    int chk_cnt = 0;
    int pass_cnt = 0;
    int wd_cnt = 0;

    pmc_transmitter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sh        (sh),
        .pclk      (pclk),
        .dout      (dout),
        .pm_din    (pm_din),
        .busy      (busy),
        .word_done (word_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && word_done) wd_cnt <= wd_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1);
    end

    // Inputs change on the falling edge; outputs read there belong to the preceding rising edge.
    task automatic step(input logic sh_v, input logic pclk_v);
        @(negedge clk);
        sh   = sh_v;
        pclk = pclk_v;
    endtask

    task automatic rand_words(output logic [31:0][15:0] w);
        for (int i = 0; i < 32; i++) w[i] = 16'($urandom);
    endtask

    // Reference receiver: the k-th strobe of a word carries bit 16-k of every column.
    task automatic shift(input int nbits, input int gap, input int drop_after, input int change_at,
                         input logic [31:0][15:0] new_dout,
                         output logic [31:0][15:0] rx, output logic busy_all);
        logic sh_v;
        sh_v     = sh;
        rx       = '0;
        busy_all = 1'b1;
        for (int k = 1; k <= nbits; k++) begin
            for (int g = 0; g < gap; g++) begin
                step(sh_v, 1'b0);
                busy_all = busy_all & busy;
            end
            step(sh_v, 1'b1);
            busy_all = busy_all & busy;
            for (int i = 0; i < 32; i++) rx[i][16-k] = pm_din[i];
            if (k == drop_after) sh_v = 1'b0;
            if (k == change_at) dout = new_dout;
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        chk_cnt++;
        if (pm_din !== 32'h0) $display("FAIL reset_pm_din: got %h want 0", pm_din);
        else pass_cnt++;
        chk_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
        else pass_cnt++;
        chk_cnt++;
        if (word_done !== 1'b0) $display("FAIL reset_word_done: got %b want 0", word_done);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0);
    endtask

    task automatic test_single_word();
        logic [31:0][15:0] exp, rx;
        logic ba;
        int w0;
        exp = '0;
        exp[0] = 16'hA5C3;
        exp[31] = 16'h8001;
        dout = exp;
        w0 = wd_cnt;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        chk_cnt++;
        if (busy !== 1'b1) $display("FAIL single_busy: got %b want 1", busy);
        else pass_cnt++;
        chk_cnt++;
        if (pm_din !== 32'h8000_0001) $display("FAIL single_msb: got %h want 80000001", pm_din);
        else pass_cnt++;
        shift(16, 3, 0, 0, '0, rx, ba);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk_cnt++;
        if (rx[0] !== 16'hA5C3) $display("FAIL single_col0: got %h want a5c3", rx[0]);
        else pass_cnt++;
        chk_cnt++;
        if (rx[31] !== 16'h8001) $display("FAIL single_col31: got %h want 8001", rx[31]);
        else pass_cnt++;
        chk_cnt++;
        if (rx !== exp) $display("FAIL single_all: got %h want %h", rx, exp);
        else pass_cnt++;
        chk_cnt++;
        if (wd_cnt - w0 !== 1) $display("FAIL single_word_done: got %0d want 1", wd_cnt - w0);
        else pass_cnt++;
        chk_cnt++;
        if (busy !== 1'b0) $display("FAIL single_idle_busy: got %b want 0", busy);
        else pass_cnt++;
        chk_cnt++;
        if (pm_din !== 32'h0) $display("FAIL single_idle_pm_din: got %h want 0", pm_din);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [31:0][15:0] exp, rx;
        logic ba;
        int w0;
        rand_words(exp);
        dout = exp;
        w0 = wd_cnt;
        step(1'b1, 1'b0);
        shift(16, 0, 0, 0, '0, rx, ba);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk_cnt++;
        if (rx !== exp) $display("FAIL b2b_words: got %h want %h", rx, exp);
        else pass_cnt++;
        chk_cnt++;
        if (ba !== 1'b1) $display("FAIL b2b_busy: got %b want 1", ba);
        else pass_cnt++;
        chk_cnt++;
        if (wd_cnt - w0 !== 1) $display("FAIL b2b_word_done: got %0d want 1", wd_cnt - w0);
        else pass_cnt++;
    endtask

    task automatic test_two_words();
        logic [31:0][15:0] snap, second, rx1, rx2;
        logic ba1, ba2;
        int w0;
        rand_words(snap);
        for (int i = 0; i < 32; i++) second[i] = 16'h1234;
        dout = snap;
        w0 = wd_cnt;
        step(1'b1, 1'b0);
        shift(16, 1, 0, 6, second, rx1, ba1);
        shift(16, 0, 0, 0, '0, rx2, ba2);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk_cnt++;
        if (rx1 !== snap) $display("FAIL two_word1: got %h want %h", rx1, snap);
        else pass_cnt++;
        chk_cnt++;
        if (rx2 !== second) $display("FAIL two_word2: got %h want %h", rx2, second);
        else pass_cnt++;
        chk_cnt++;
        if (wd_cnt - w0 !== 2) $display("FAIL two_word_done: got %0d want 2", wd_cnt - w0);
        else pass_cnt++;
    endtask

    task automatic test_abort();
        logic [31:0][15:0] snap, rx;
        logic ba;
        int w0;
        rand_words(snap);
        dout = snap;
        w0 = wd_cnt;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk_cnt++;
        if (busy !== 1'b1) $display("FAIL abort_waiting_busy: got %b want 1", busy);
        else pass_cnt++;
        step(1'b0, 1'b0);
        chk_cnt++;
        if (busy !== 1'b0) $display("FAIL abort_idle_busy: got %b want 0", busy);
        else pass_cnt++;
        chk_cnt++;
        if (pm_din !== 32'h0) $display("FAIL abort_idle_pm_din: got %h want 0", pm_din);
        else pass_cnt++;
        step(1'b0, 1'b0);
        chk_cnt++;
        if (wd_cnt - w0 !== 0) $display("FAIL abort_word_done: got %0d want 0", wd_cnt - w0);
        else pass_cnt++;

        rand_words(snap);
        dout = snap;
        w0 = wd_cnt;
        step(1'b1, 1'b0);
        shift(16, 2, 5, 0, '0, rx, ba);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk_cnt++;
        if (rx !== snap) $display("FAIL abort_late_word: got %h want %h", rx, snap);
        else pass_cnt++;
        chk_cnt++;
        if (ba !== 1'b1) $display("FAIL abort_late_busy: got %b want 1", ba);
        else pass_cnt++;
        chk_cnt++;
        if (busy !== 1'b0) $display("FAIL abort_late_idle: got %b want 0", busy);
        else pass_cnt++;
        chk_cnt++;
        if (wd_cnt - w0 !== 1) $display("FAIL abort_late_done: got %0d want 1", wd_cnt - w0);
        else pass_cnt++;
    endtask

    task automatic test_edge_pclk();
        logic [31:0][15:0] snap, rx;
        logic ba;
        rand_words(snap);
        dout = snap;
        step(1'b1, 1'b1);
        shift(16, 0, 0, 0, '0, rx, ba);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk_cnt++;
        if (rx !== snap) $display("FAIL edge_pclk_word: got %h want %h", rx, snap);
        else pass_cnt++;
        chk_cnt++;
        if (busy !== 1'b0) $display("FAIL edge_pclk_idle: got %b want 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [31:0][15:0] snap, rx;
        logic ba;
        rand_words(snap);
        dout = snap;
        step(1'b1, 1'b0);
        shift(8, 1, 0, 0, '0, rx, ba);
        #2 rst_n = 1'b0;
        #1;
        chk_cnt++;
        if (pm_din !== 32'h0) $display("FAIL rstmid_pm_din: got %h want 0", pm_din);
        else pass_cnt++;
        chk_cnt++;
        if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy);
        else pass_cnt++;
        chk_cnt++;
        if (word_done !== 1'b0) $display("FAIL rstmid_word_done: got %b want 0", word_done);
        else pass_cnt++;
        step(1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0);
        rand_words(snap);
        dout = snap;
        step(1'b1, 1'b0);
        shift(16, 1, 0, 0, '0, rx, ba);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk_cnt++;
        if (rx !== snap) $display("FAIL rstmid_fresh_word: got %h want %h", rx, snap);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_two_words();
        test_abort();
        test_edge_pclk();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
